cpu_control_fsm: RTL and testbench
==================================

// Module: cpu_control_fsm
// PURPOSE
//   Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU.
//   Drives the register file from the initiator side: read addresses, the write
//   port (write_enable/addr/data) and pc_write_enable, using pc_out as the fetch
//   address. Fetches from instruction memory over a req/valid handshake, runs an
//   internal 8-bit ALU and keeps zero/carry flags plus a retired-instruction count.
// PARAMETERS
//   FETCH_TIMEOUT  16  max cycles in FETCH without imem_valid before fetch error (>=2)
// PORTS
//   clk              in   1   single clock, all logic on posedge
//   reset            in   1   synchronous, active-low (0 = reset)
//   start            in   1   IDLE -> FETCH request
//   stop             in   1   sampled in WB; 1 -> return to IDLE after this instr
//   imem_req         out  1   fetch request, held high for the whole FETCH state
//   imem_addr        out  8   fetch address = pc_out while in FETCH, else 0
//   imem_valid       in   1   instruction data valid; ignored outside FETCH
//   imem_rdata       in   8   instruction byte
//   pc_out           in   8   current PC from the register file
//   read_addr1       out  2   rs1 field of the latched IR
//   read_addr2       out  2   rs2 field of the latched IR
//   read_data1       in   8   register-file asynchronous read data, port 1
//   read_data2       in   8   register-file asynchronous read data, port 2
//   write_enable     out  1   one-cycle write strobe (WB state only)
//   write_addr       out  2   rd field of the latched IR
//   write_data       out  8   ALU result register
//   pc_write_enable  out  1   one-cycle PC increment strobe (WB state only)
//   flag_zero        out  1   result of the last retired instruction == 0
//   flag_carry       out  1   ADD carry-out / SUB borrow; 0 for AND/XOR
//   busy             out  1   state not IDLE/HALTED/ERROR
//   halted           out  1   HALT executed (sticky until reset)
//   fetch_err        out  1   fetch timeout occurred (sticky until reset)
//   instr_count      out  16  retired-instruction count, wraps 0xFFFF -> 0
// BEHAVIOUR
//   - Reset (reset=0 at posedge): state=IDLE; IR, result, flags, timeout counter
//     and instr_count = 0. All outputs read 0 while reset=0. write_enable and
//     pc_write_enable are combinationally gated with reset, so no write can occur
//     in a cycle where reset=0.
//   - ISA: IR[7:6]=op, [5:4]=rd, [3:2]=rs1, [1:0]=rs2. op 00 ADD, 01 SUB (rs1-rs2),
//     10 AND, 11 XOR. IR==8'hFF is HALT (overrides XOR). Results are mod 256.
//   - States: IDLE, FETCH, DECODE, EXEC, WB, HALTED, ERROR.
//   - IDLE: start=1 -> FETCH next cycle.
//   - FETCH: imem_req=1, imem_addr=pc_out. If imem_valid=1, IR<=imem_rdata ->
//     DECODE; a same-cycle valid is accepted (zero wait). Otherwise the timeout
//     counter increments; the FETCH_TIMEOUT-th consecutive cycle without valid
//     -> ERROR. The counter clears on entry to FETCH.
//   - DECODE: read_addr1/2 driven from IR (held stable from DECODE through WB).
//     IR==8'hFF -> HALTED; otherwise -> EXEC.
//   - EXEC: result<=ALU(read_data1, read_data2); carry/zero computed into shadow
//     registers -> WB.
//   - WB (exactly one cycle): write_enable=1, write_addr=rd, write_data=result,
//     pc_write_enable=1. At the closing edge, flags update and instr_count+1.
//     Then stop=1 -> IDLE, else -> FETCH.
//   - Minimum 4 cycles per instruction (FETCH, DECODE, EXEC, WB) with zero-wait
//     memory. rd==rs1/rs2 is legal: operands are consumed in EXEC, before the
//     write.
//   - HALTED / ERROR: terminal until reset. No strobes, imem_req=0, start ignored.
//     HALT does not increment the PC or instr_count.
//   - start while busy: ignored. stop outside WB: ignored.
// TESTING
//   1 reset=0 for 2 cycles, then release -> all outputs 0, busy=0, no imem_req.
//   2 R2=05, R3=07, start, imem returns 8'h1B zero-wait -> 4th cycle
//     write_enable=1, addr=1, data=0C, pc_write_enable=1; zero=0, carry=0,
//     count=1.
//   3 SUB 8'h5B with R2=03, R3=03 -> data=00, zero=1, carry=0; with R2=02, R3=05
//     -> data=FD, carry=1. ADD FF+01 -> 00, zero=1, carry=1.
//   4 start, imem_valid held 0 -> ERROR after 16 FETCH cycles: fetch_err=1,
//     imem_req=0, no strobes; valid after 3 wait cycles -> normal completion.
//   5 imem returns 8'hFF -> halted=1, no write/pc strobes, count unchanged,
//     start ignored.
//   6 reset=0 during the WB cycle -> write_enable=0 that cycle, IDLE next, count
//     unchanged.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit CPU with an internal ALU, zero/carry flags and a retired-instruction counter.
// Four cycles per instruction with zero-wait fetch. A fetch that sees no imem_valid for FETCH_TIMEOUT cycles ends in a terminal ERROR state.
module cpu_control_fsm #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [7:0]  imem_rdata,
  input  logic [7:0]  pc_out,
  output logic [1:0]  read_addr1,
  output logic [1:0]  read_addr2,
  input  logic [7:0]  read_data1,
  input  logic [7:0]  read_data2,
  output logic        write_enable,
  output logic [1:0]  write_addr,
  output logic [7:0]  write_data,
  output logic        pc_write_enable,
  output logic        flag_zero,
  output logic        flag_carry,
  output logic        busy,
  output logic        halted,
  output logic        fetch_err,
  output logic [15:0] instr_count
);

  localparam int TW = $clog2(FETCH_TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED, S_ERROR
  } state_t;

  state_t        state, state_next;
  logic [7:0]    ir, ir_next;
  logic [7:0]    result, result_next;
  logic          zero_sh, zero_sh_next, carry_sh, carry_sh_next;
  logic          zero_q, zero_next, carry_q, carry_next;
  logic [TW-1:0] tcount, tcount_next;
  logic [15:0]   count, count_next;
  logic [7:0]    alu_res;
  logic          alu_carry;

  always_comb begin
    alu_res   = 8'h00;
    alu_carry = 1'b0;
    unique case (ir[7:6])
      2'b00: {alu_carry, alu_res} = {1'b0, read_data1} + {1'b0, read_data2};
      2'b01: begin
        alu_res   = read_data1 - read_data2;
        alu_carry = read_data1 < read_data2;
      end
      2'b10: alu_res = read_data1 & read_data2;
      default: alu_res = read_data1 ^ read_data2;
    endcase
  end

  always_comb begin
    state_next    = state;
    ir_next       = ir;
    result_next   = result;
    zero_sh_next  = zero_sh;
    carry_sh_next = carry_sh;
    zero_next     = zero_q;
    carry_next    = carry_q;
    tcount_next   = tcount;
    count_next    = count;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next  = S_FETCH;
          tcount_next = '0;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_next    = imem_rdata;
          state_next = S_DECODE;
        end else if (tcount == TO_LAST) begin
          state_next = S_ERROR;
        end else begin
          tcount_next = tcount + TW'(1);
        end
      end
      S_DECODE: state_next = (ir == 8'hFF) ? S_HALTED : S_EXEC;
      S_EXEC: begin
        result_next   = alu_res;
        carry_sh_next = alu_carry;
        zero_sh_next  = (alu_res == 8'h00);
        state_next    = S_WB;
      end
      S_WB: begin
        // Flags become architectural only once the instruction retires.
        zero_next  = zero_sh;
        carry_next = carry_sh;
        count_next = count + 16'd1;
        if (stop) begin
          state_next = S_IDLE;
        end else begin
          state_next  = S_FETCH;
          tcount_next = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      ir       <= 8'h00;
      result   <= 8'h00;
      zero_sh  <= 1'b0;
      carry_sh <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      tcount   <= '0;
      count    <= 16'h0000;
    end else begin
      state    <= state_next;
      ir       <= ir_next;
      result   <= result_next;
      zero_sh  <= zero_sh_next;
      carry_sh <= carry_sh_next;
      zero_q   <= zero_next;
      carry_q  <= carry_next;
      tcount   <= tcount_next;
      count    <= count_next;
    end
  end

  // Every output is forced low while reset is asserted, so no strobe can escape in a reset cycle.
  assign imem_req        = reset && (state == S_FETCH);
  assign imem_addr       = (reset && (state == S_FETCH)) ? pc_out : 8'h00;
  assign read_addr1      = reset ? ir[3:2] : 2'b00;
  assign read_addr2      = reset ? ir[1:0] : 2'b00;
  assign write_enable    = reset && (state == S_WB);
  assign write_addr      = reset ? ir[5:4] : 2'b00;
  assign write_data      = reset ? result : 8'h00;
  assign pc_write_enable = reset && (state == S_WB);
  assign flag_zero       = reset && zero_q;
  assign flag_carry      = reset && carry_q;
  assign busy            = reset && (state inside {S_FETCH, S_DECODE, S_EXEC, S_WB});
  assign halted          = reset && (state == S_HALTED);
  assign fetch_err       = reset && (state == S_ERROR);
  assign instr_count     = reset ? count : 16'h0000;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: a behavioural register file/PC around the DUT, with expected results computed from the ISA using integer arithmetic.
module tb_cpu_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stop, imem_valid;
  logic [7:0]  imem_rdata;
  logic        imem_req, write_enable, pc_write_enable;
  logic [7:0]  imem_addr, write_data, read_data1, read_data2;
  logic [1:0]  read_addr1, read_addr2, write_addr;
  logic        flag_zero, flag_carry, busy, halted, fetch_err;
  logic [15:0] instr_count;

  logic [7:0] rf [4];
  logic [7:0] pc;
  logic [7:0] pre_rf [4];
  logic [7:0] pre_pc;
  logic       pre_load = 1'b0;

  int total = 0;
  int bad = 0;
  int m_count = 0;

  assign read_data1 = rf[read_addr1];
  assign read_data2 = rf[read_addr2];

  cpu_control_fsm #(.FETCH_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .pc_out(pc),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .pc_write_enable(pc_write_enable), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .busy(busy), .halted(halted), .fetch_err(fetch_err), .instr_count(instr_count)
  );

  // Register file and PC owned by the bench; the DUT is the only writer outside preloads.
  always @(posedge clk) begin
    if (pre_load) begin
      for (int i = 0; i < 4; i++) rf[i] = pre_rf[i];
      pc = pre_pc;
    end else begin
      if (write_enable) rf[write_addr] = write_data;
      if (pc_write_enable) pc = pc + 8'd1;
    end
  end

  task automatic preload(input logic [7:0] r0, input logic [7:0] r1,
                         input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] p);
    pre_rf[0] = r0; pre_rf[1] = r1; pre_rf[2] = r2; pre_rf[3] = r3; pre_pc = p;
    pre_load = 1'b1;
    @(negedge clk);
    pre_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0; imem_valid = 1'b0; imem_rdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_count = 0;
    @(negedge clk);
  endtask

  task automatic begin_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL start_fetch: imem_req=%0b want 1", imem_req); end
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves it in FETCH (stp=0) or IDLE (stp=1).
  task automatic run_instr(input logic [7:0] instr, input int waits, input logic stp);
    logic [7:0] a, b, exp_res, pc0;
    logic       exp_c;
    logic [1:0] rd;
    int s;
    a = rf[instr[3:2]];
    b = rf[instr[1:0]];
    rd = instr[5:4];
    exp_c = 1'b0;
    case (instr[7:6])
      2'b00: begin s = int'(a) + int'(b); exp_c = (s > 255); end
      2'b01: begin s = int'(a) - int'(b); exp_c = (s < 0); end
      2'b10: s = int'(a & b);
      default: s = int'(a ^ b);
    endcase
    exp_res = 8'(s);
    for (int w = 0; w < waits; w++) begin
      imem_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== pc) begin
      bad++; $display("FAIL fetch_req: req=%0b addr=%0h want req=1 addr=%0h", imem_req, imem_addr, pc);
    end
    imem_valid = 1'b1; imem_rdata = instr;
    @(negedge clk);
    imem_valid = 1'b0; imem_rdata = 8'($urandom);
    total++;
    if (read_addr1 !== instr[3:2] || read_addr2 !== instr[1:0] || write_enable !== 1'b0) begin
      bad++; $display("FAIL decode: ra1=%0d ra2=%0d we=%0b want %0d %0d 0", read_addr1, read_addr2, write_enable, instr[3:2], instr[1:0]);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (write_enable !== 1'b1 || pc_write_enable !== 1'b1 || write_addr !== rd || write_data !== exp_res) begin
      bad++; $display("FAIL wb_strobe ir=%0h: we=%0b pcwe=%0b addr=%0d data=%0h want 1 1 %0d %0h",
                      instr, write_enable, pc_write_enable, write_addr, write_data, rd, exp_res);
    end
    pc0 = pc;
    stop = stp;
    @(negedge clk);
    stop = 1'b0;
    m_count++;
    total++;
    if (flag_zero !== (exp_res == 8'h00) || flag_carry !== exp_c || instr_count !== 16'(m_count)) begin
      bad++; $display("FAIL retire ir=%0h: z=%0b c=%0b cnt=%0d want %0b %0b %0d",
                      instr, flag_zero, flag_carry, instr_count, exp_res == 8'h00, exp_c, m_count);
    end
    total++;
    if (rf[rd] !== exp_res || pc !== pc0 + 8'd1 || imem_req !== !stp || write_enable !== 1'b0) begin
      bad++; $display("FAIL after_wb ir=%0h: rd=%0h pc=%0h req=%0b we=%0b want %0h %0h %0b 0",
                      instr, rf[rd], pc, imem_req, write_enable, exp_res, pc0 + 8'd1, !stp);
    end
  endtask

  task automatic test_reset();
    logic [39:0] outs;
    preload(8'h11, 8'h22, 8'h33, 8'h44, 8'h3C);
    reset = 1'b0; start = 1'b1; stop = 1'b1; imem_valid = 1'b1; imem_rdata = 8'h1B;
    @(negedge clk);
    @(negedge clk);
    outs = {imem_req, imem_addr, read_addr1, read_addr2, write_enable, write_addr, write_data,
            pc_write_enable, flag_zero, flag_carry, busy, halted, fetch_err, instr_count};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %0h want 0", outs); end
    reset = 1'b1; start = 1'b0; stop = 1'b0; imem_valid = 1'b0;
    m_count = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || instr_count !== 16'h0 || flag_zero !== 1'b0 || flag_carry !== 1'b0) begin
      bad++; $display("FAIL post_reset: busy=%0b req=%0b cnt=%0d z=%0b c=%0b want all 0", busy, imem_req, instr_count, flag_zero, flag_carry);
    end
  endtask

  task automatic test_add_basic();
    preload(8'h00, 8'h00, 8'h05, 8'h07, 8'h00);
    begin_run();
    run_instr(8'h1B, 0, 1'b1);
  endtask

  task automatic test_flags();
    preload(8'h00, 8'h00, 8'h03, 8'h03, 8'h10);
    begin_run();
    run_instr(8'h5B, 0, 1'b1);
    preload(8'h00, 8'h00, 8'h02, 8'h05, 8'h20);
    begin_run();
    run_instr(8'h5B, 0, 1'b1);
    preload(8'h00, 8'h00, 8'hFF, 8'h01, 8'h30);
    begin_run();
    run_instr(8'h1B, 0, 1'b1);
  endtask

  task automatic test_timeout();
    int n;
    logic seen;
    do_reset();
    begin_run();
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1) break;
      n++;
    end
    total++;
    if (n != 16) begin bad++; $display("FAIL timeout_cycles: got %0d want 16", n); end
    total++;
    if (fetch_err !== 1'b1 || busy !== 1'b0 || halted !== 1'b0) begin
      bad++; $display("FAIL error_state: err=%0b busy=%0b halted=%0b want 1 0 0", fetch_err, busy, halted);
    end
    seen = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (write_enable || pc_write_enable || imem_req || !fetch_err) seen = 1'b1;
    end
    start = 1'b0;
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL error_terminal: activity=%0b want 0", seen); end
    do_reset();
    preload(8'h09, 8'h41, 8'h80, 8'hC3, 8'h50);
    begin_run();
    run_instr(8'h86, 3, 1'b0);
    run_instr(8'hE1, 15, 1'b0);
    run_instr(8'h2C, 15, 1'b1);
  endtask

  task automatic test_halt();
    logic seen;
    logic [7:0] pc_h;
    do_reset();
    preload(8'h01, 8'h02, 8'h03, 8'h04, 8'h60);
    begin_run();
    run_instr(8'h06, 1, 1'b0);
    imem_valid = 1'b1; imem_rdata = 8'hFF;
    @(negedge clk);
    imem_valid = 1'b0;
    pc_h = pc;
    @(negedge clk);
    total++;
    if (halted !== 1'b1 || busy !== 1'b0 || write_enable !== 1'b0) begin
      bad++; $display("FAIL halt_state: halted=%0b busy=%0b we=%0b want 1 0 0", halted, busy, write_enable);
    end
    seen = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (write_enable || pc_write_enable || imem_req || !halted) seen = 1'b1;
    end
    start = 1'b0;
    total++;
    if (seen !== 1'b0 || instr_count !== 16'(m_count) || pc !== pc_h) begin
      bad++; $display("FAIL halt_terminal: activity=%0b cnt=%0d pc=%0h want 0 %0d %0h", seen, instr_count, pc, m_count, pc_h);
    end
  endtask

  task automatic test_reset_in_wb();
    logic [7:0] pc0;
    do_reset();
    preload(8'h00, 8'hAA, 8'h05, 8'h07, 8'h70);
    begin_run();
    imem_valid = 1'b1; imem_rdata = 8'h1B;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (write_enable !== 1'b1) begin bad++; $display("FAIL wb_reached: we=%0b want 1", write_enable); end
    pc0 = pc;
    reset = 1'b0;
    #1;
    total++;
    if (write_enable !== 1'b0 || pc_write_enable !== 1'b0) begin
      bad++; $display("FAIL wb_gated: we=%0b pcwe=%0b want 0 0", write_enable, pc_write_enable);
    end
    @(negedge clk);
    reset = 1'b1;
    m_count = 0;
    @(negedge clk);
    total++;
    if (rf[1] !== 8'hAA || pc !== pc0 || busy !== 1'b0 || imem_req !== 1'b0 || instr_count !== 16'h0) begin
      bad++; $display("FAIL wb_reset_after: r1=%0h pc=%0h busy=%0b req=%0b cnt=%0d want aa %0h 0 0 0",
                      rf[1], pc, busy, imem_req, instr_count, pc0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] instr;
    logic       stp;
    do_reset();
    preload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    begin_run();
    for (int k = 0; k < 40; k++) begin
      instr = 8'($urandom);
      if (instr == 8'hFF) instr = 8'h7E;
      stp = (k == 39) || ($urandom_range(0, 7) == 0);
      run_instr(instr, int'($urandom_range(0, 4)), stp);
      if (stp && k != 39) begin
        preload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), pc);
        begin_run();
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; imem_valid = 1'b0; imem_rdata = 8'h00;
    test_reset();
    test_add_basic();
    test_flags();
    test_timeout();
    test_halt();
    test_reset_in_wb();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
